// File: rtl/bcd_to_binary_converter_if.sv
// rtl/bcd_to_binary_converter_if.sv - start/ready/done handshake and result bundle for the BCD-to-binary converter
interface bcd_to_binary_converter_if #(
    parameter int DIGITS = 10,
    parameter int WIDTH  = 32
);
    logic                start_i;
    logic [4*DIGITS-1:0] BCD_i;
    logic                ready_o;
    logic                done_o;
    logic [WIDTH-1:0]    binary_o;
    logic                overflow_o;
    logic                invalid_o;

    modport master (
        output start_i, BCD_i,
        input  ready_o, done_o, binary_o, overflow_o, invalid_o
    );

    modport slave (
        input  start_i, BCD_i,
        output ready_o, done_o, binary_o, overflow_o, invalid_o
    );
endinterface

// File: rtl/bcd_to_binary_converter.sv
// rtl/bcd_to_binary_converter.sv - sequential packed-BCD to binary converter, one digit per clock, MSD first
module bcd_to_binary_converter #(
    parameter int DIGITS = 10,
    parameter int WIDTH  = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    bcd_to_binary_converter_if.slave  bus
);
    localparam int ACCW = WIDTH + 4;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t              state, state_n;
    logic [4*DIGITS-1:0] bcd_q, bcd_n;
    logic [ACCW-1:0]     acc, acc_n;
    logic [IDXW-1:0]     idx, idx_n;
    logic                ovf, ovf_n;
    logic                inv, inv_n;
    logic [WIDTH-1:0]    binary, binary_n;
    logic                overflow, overflow_n;
    logic                invalid, invalid_n;

    logic [3:0]          digit;
    logic [ACCW-1:0]     product;
    logic                step_ovf;
    logic [ACCW-1:0]     step_acc;
    logic                ovf_acc;
    logic                inv_acc;

    assign digit    = 4'(bcd_q >> {idx, 2'b00});
    assign product  = (acc << 3) + (acc << 1) + ACCW'(digit);
    assign step_ovf = |product[ACCW-1:WIDTH];
    // Clamp to 2^WIDTH so repeated *10 can never wrap back into range
    assign step_acc = step_ovf ? {4'b0001, {WIDTH{1'b0}}} : product;
    assign ovf_acc  = ovf | step_ovf;
    assign inv_acc  = inv | (digit > 4'd9);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            bcd_q    <= '0;
            acc      <= '0;
            idx      <= '0;
            ovf      <= 1'b0;
            inv      <= 1'b0;
            binary   <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            state    <= state_n;
            bcd_q    <= bcd_n;
            acc      <= acc_n;
            idx      <= idx_n;
            ovf      <= ovf_n;
            inv      <= inv_n;
            binary   <= binary_n;
            overflow <= overflow_n;
            invalid  <= invalid_n;
        end
    end

    always_comb begin
        state_n    = state;
        bcd_n      = bcd_q;
        acc_n      = acc;
        idx_n      = idx;
        ovf_n      = ovf;
        inv_n      = inv;
        binary_n   = binary;
        overflow_n = overflow;
        invalid_n  = invalid;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    bcd_n   = bus.BCD_i;
                    acc_n   = '0;
                    idx_n   = IDXW'(DIGITS - 1);
                    ovf_n   = 1'b0;
                    inv_n   = 1'b0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                acc_n = step_acc;
                ovf_n = ovf_acc;
                inv_n = inv_acc;
                idx_n = idx - 1'b1;
                if (idx == '0) begin
                    state_n    = DONE;
                    invalid_n  = inv_acc;
                    overflow_n = ovf_acc;
                    if (inv_acc)
                        binary_n = '0;
                    else if (ovf_acc)
                        binary_n = '1;
                    else
                        binary_n = step_acc[WIDTH-1:0];
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready_o    = (state == IDLE);
    assign bus.done_o     = (state == DONE);
    assign bus.binary_o   = binary;
    assign bus.overflow_o = overflow;
    assign bus.invalid_o  = invalid;
endmodule
